// File: rtl/led_lane_serializer_if.sv
// Frame request, pixel data and LED pin bundle between the statistics logic and the lane serializer.
interface led_lane_serializer_if #(
    parameter int CH = 8,
    parameter int DW = 4
);
    logic               en;
    logic               start;
    logic               color_order;
    logic               msb_first;
    logic [CH*DW-1:0]   mean_r;
    logic [CH*DW-1:0]   mean_g;
    logic [CH*DW-1:0]   mean_b;
    logic               busy;
    logic               done;
    logic               cko_o;
    logic [CH-1:0]      sdo;
    logic               lat_o;

    modport master (
        output en, start, color_order, msb_first, mean_r, mean_g, mean_b,
        input  busy, done, cko_o, sdo, lat_o
    );

    modport slave (
        input  en, start, color_order, msb_first, mean_r, mean_g, mean_b,
        output busy, done, cko_o, sdo, lat_o
    );
endinterface

// File: rtl/led_lane_serializer.sv
// Multi-lane LED serializer: captures per-lane RGB words on start, shifts them out on CH lanes
// with a shared bit clock, then pulses a latch strobe and a done flag.
module led_lane_serializer #(
    parameter int CH        = 8,
    parameter int DW        = 4,
    parameter int DIV       = 4,
    parameter int LATCH_CYC = 8
) (
    input  logic                 clk_fast,
    input  logic                 rst,
    led_lane_serializer_if.slave bus
);
    localparam int NB = 3 * DW;
    localparam int BW = $clog2(NB);
    localparam int VW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CH-1:0][NB-1:0]  frame_in;
    logic [CH-1:0][NB-1:0]  shadow;
    logic [CH*DW-1:0]       first_c, second_c;
    logic [CH-1:0]          sdo_w;
    logic [BW-1:0]          bit_cnt;
    logic [VW-1:0]          div_cnt;
    logic [LW-1:0]          lat_cnt;
    logic                   phase;
    logic                   accept, div_end, last_bit, lat_end;

    assign first_c  = bus.color_order ? bus.mean_g : bus.mean_r;
    assign second_c = bus.color_order ? bus.mean_r : bus.mean_g;

    // Frame word is stored in transmit order: bit 0 goes out first.
    for (genvar i = 0; i < CH; i++) begin : g_lane
        for (genvar j = 0; j < DW; j++) begin : g_bit
            assign frame_in[i][j]        = bus.msb_first ? first_c[i*DW + DW-1-j]  : first_c[i*DW + j];
            assign frame_in[i][DW + j]   = bus.msb_first ? second_c[i*DW + DW-1-j] : second_c[i*DW + j];
            assign frame_in[i][2*DW + j] = bus.msb_first ? bus.mean_b[i*DW + DW-1-j] : bus.mean_b[i*DW + j];
        end
        assign sdo_w[i] = shadow[i][bit_cnt];
    end

    assign accept   = bus.start & bus.en;
    assign div_end  = (div_cnt == VW'(DIV - 1));
    assign last_bit = (bit_cnt == BW'(NB - 1));
    assign lat_end  = (lat_cnt == LW'(LATCH_CYC - 1));

    always_ff @(posedge clk_fast) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.cko_o = 1'b0;
        bus.lat_o = 1'b0;
        bus.sdo   = '0;
        case (state)
            IDLE: if (accept) state_nxt = SHIFT;
            SHIFT: begin
                bus.busy  = 1'b1;
                bus.cko_o = phase;
                bus.sdo   = sdo_w;
                if (phase && div_end && last_bit) state_nxt = LATCH;
            end
            LATCH: begin
                bus.busy  = 1'b1;
                bus.lat_o = 1'b1;
                if (lat_end) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.en) state_nxt = IDLE;
    end

    // Bit index advances only on the high-to-low transition, so sdo holds through the high phase.
    always_ff @(posedge clk_fast) begin
        if (state == IDLE && accept) begin
            shadow  <= frame_in;
            bit_cnt <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (state == SHIFT) begin
            if (div_end) begin
                div_cnt <= '0;
                phase   <= ~phase;
                if (phase && !last_bit) bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_fast) begin
        if (state == LATCH) lat_cnt <= lat_cnt + 1'b1;
        else                lat_cnt <= '0;
    end
endmodule

// File: doc/led_lane_serializer.md
# led_lane_serializer

Parametrised multi-lane LED serializer that succeeds the fixed 8-lane, 4-bit LED control path. On a `start` pulse it captures per-lane R/G/B intensity words and shifts them out in parallel on `CH` serial data lanes with a shared bit clock `cko_o`, then issues a latch strobe and a `done` pulse. It sits in the `clk_fast` domain between the frame-statistics logic that produces the per-lane means and the LED driver pins. It adds configurable lane count, colour depth, bit-clock divide, colour order, bit order and abort behaviour.

## Interface
- `CH`, 8, number of parallel LED lanes (≥1)
- `DW`, 4, bits per colour component (1..16)
- `DIV`, 4, `clk_fast` cycles per `cko_o` half-period (≥1)
- `LATCH_CYC`, 8, `lat_o` high duration in cycles (≥1)

- `clk_fast` in 1 — single block clock
- `rst` in 1 — synchronous, active-high reset
- `en` in 1 — block enable; low aborts any frame in progress
- `start` in 1 — single-cycle frame request
- `color_order` in 1 — 0 = R,G,B; 1 = G,R,B
- `msb_first` in 1 — 1 = MSB first within each component, 0 = LSB first
- `mean_r` in CH*DW — lane i red at bits [i*DW +: DW]
- `mean_g` in CH*DW — lane i green, same packing
- `mean_b` in CH*DW — lane i blue, same packing
- `busy` out 1 — frame in progress
- `done` out 1 — one-cycle pulse at normal frame completion
- `cko_o` out 1 — shared serial bit clock
- `sdo` out CH — serial data, bit i = lane i
- `lat_o` out 1 — latch strobe after the last bit

## Operation
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE: all outputs 0. `start`=1 and `en`=1 in the same cycle → capture `mean_r/g/b`, `color_order` and `msb_first` into shadow registers, go to SHIFT. `start` with `en`=0 is ignored.
- Per-lane frame word is 3*DW bits, components in the selected order, each component in the selected bit order. Inputs may change freely after capture.
- SHIFT: for each of 3*DW bits, `cko_o`=0 for DIV cycles, then 1 for DIV cycles. `sdo` updates only at the start of each low phase and is stable across the high phase. After the last high phase go to LATCH.
- LATCH: `cko_o`=0, `sdo`=0, `lat_o`=1 for LATCH_CYC cycles, then go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- `busy`=1 in SHIFT and LATCH only.
- `start` while `busy`: ignored. It is not queued.
- `en`=0 in SHIFT or LATCH: next cycle all outputs are 0 and the state is IDLE. No `done` is issued.
- `rst`=1 at any time: next cycle all outputs are 0 and the state is IDLE, overriding `start`/`en`. Shadow registers need no reset.
- Bit counter width is clog2(3*DW). Divide counter width is clog2(DIV). Latch counter width is clog2(LATCH_CYC). Counters never wrap within a frame.

## Timing
- Reset values: `busy`=0, `done`=0, `cko_o`=0, `sdo`=0, `lat_o`=0.
- Start accepted at edge k:
  - `busy`=1 and first bit on `sdo` from cycle k+1.
  - `cko_o` first rises at k+1+DIV.
- Shift phase lasts S = 2*DIV*3*DW cycles (k+1 .. k+S).
- `lat_o`=1 on cycles k+S+1 .. k+S+LATCH_CYC.
- `done`=1 on cycle k+S+LATCH_CYC+1. `busy` falls on the same cycle.
- Defaults: S=96; `lat_o` on k+97..k+104; `done` at k+105.
- Back-to-back: a `start` in the `done` cycle is ignored. The earliest accepted `start` is the cycle after `done`.
- Abort via `en` or `rst`: response has one-cycle latency.

## Test plan
- Defaults; lane i R=G=B=i+1; RGB; MSB first; `start` at k → `sdo[7]` = 1000 1000 1000; `sdo[0]` = 0001 0001 0001; `cko_o` 12 rising edges; `lat_o` high k+97..k+104; `done` single pulse at k+105.
- Same data, `msb_first`=0 → `sdo[0]` = 1000 1000 1000; `sdo[2]` (value 3) = 1100 1100 1100.
- Lane 0 R=0xA, G=0x5, B=0xF, `color_order`=1 → `sdo[0]` = 0101 1010 1111. Change `mean_*` at k+2 → serial output unchanged.
- `en`=0 at k+40 → from k+41 `busy`=0, `cko_o`=0, `sdo`=0; no `done`, no `lat_o`. A new `start` at k+45 runs a full frame.
- `start` pulses at k+10 and k+105 → both ignored. Only one frame runs, with `done` at k+105.
- `rst`=1 at k+60 → all outputs 0 at k+61. `start` with `en`=0 → no activity. Parameter sweep CH=3, DW=8, DIV=1, LATCH_CYC=1 → `done` at k+1+48+1 = k+50.
